// File: rtl/risky_defs.sv
// Shared definitions for the risky core bus arbiters: the arbiter state encoding
// and the fixed requester index assignment on the internal bus.
package risky_defs;

    localparam logic [1:0] RISKY_ARB_IDLE  = 2'd0;
    localparam logic [1:0] RISKY_ARB_GRANT = 2'd1;
    localparam logic [1:0] RISKY_ARB_TURN  = 2'd2;

    localparam int RISKY_ARB_PC      = 0;
    localparam int RISKY_ARB_REGFILE = 1;
    localparam int RISKY_ARB_ALU     = 2;
    localparam int RISKY_ARB_MEM     = 3;

endpackage

// File: rtl/risky_rr_pick.sv
// Combinational round-robin picker: scans from owner+1 upward with wrap, so the
// previous owner is considered last and wins only when it is the sole requester.
module risky_rr_pick #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    owner,
    output logic [N_REQ-1:0] win_oh,
    output logic [OW-1:0]    win_idx,
    output logic             found
);

    logic [OW-1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OW'((int'(owner) + i) % N_REQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                win_oh[cand]  = 1'b1;
                win_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/risky_bus_arb.sv
// Round-robin arbiter for the shared risky core bus with a dead turnaround cycle
// between owners. Optional grant timeout: define RISKY_BUS_ARB_TIMEOUT_EN.
module risky_bus_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         last,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     timeout_err
);

    import risky_defs::*;

    localparam int OW = $clog2(N_REQ);

    // Handshake: req is a level request that the unit holds for the whole
    // transfer; gnt[i] high means unit i owns the bus this cycle. The owner
    // releases by dropping req, or by holding req with last high on its final
    // beat. Non-owner req/last are ignored until the next arbitration.
    logic [1:0]       state;
    logic [N_REQ-1:0] pick_oh;
    logic [OW-1:0]    pick_idx;
    logic             pick_any;
    logic             rel;
    logic             to_hit;

    risky_rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
        .req     (req),
        .owner   (owner),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .found   (pick_any)
    );

    assign rel = !req[owner] || last[owner];

`ifdef RISKY_BUS_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    // to_cnt counts completed grant cycles; this edge ends cycle TIMEOUT.
    assign to_hit = (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == RISKY_ARB_GRANT) begin
                to_cnt <= to_cnt + 8'd1;
                if (to_hit && !rel) begin
                    timeout_err <= 1'b1;
                end
            end else begin
                to_cnt <= 8'd0;
            end
        end
    end
`else
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT > 255);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RISKY_ARB_IDLE;
            gnt   <= '0;
            owner <= OW'(N_REQ - 1);
            busy  <= 1'b0;
        end else begin
            case (state)
                RISKY_ARB_IDLE, RISKY_ARB_TURN: begin
                    if (pick_any) begin
                        state <= RISKY_ARB_GRANT;
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                        busy  <= 1'b1;
                    end else begin
                        state <= RISKY_ARB_IDLE;
                    end
                end
                RISKY_ARB_GRANT: begin
                    if (rel || to_hit) begin
                        state <= RISKY_ARB_TURN;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RISKY_ARB_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risky_bus_arb.sv
// Bench for risky_bus_arb: directed scenarios plus randomized req/last traffic
// checked against a cycle-level model of the arbitration rules.
module tb_risky_bus_arb;

    localparam int NREQ  = 4;
    localparam int TO_V  = 4;
`ifdef RISKY_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    logic [NREQ-1:0] gnt;
    logic [1:0]      owner;
    logic            busy;
    logic            timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    // expected {timeout_err, busy, owner, gnt} after each clock edge
    logic [7:0] exp_q[$];

    // model: granted index (-1 none), last owner, completed grant cycles
    int m_idx;
    int m_owner;
    int m_len;

    risky_bus_arb #(.N_REQ(NREQ), .TIMEOUT(TO_V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (last),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int o);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (o + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_pack(input bit terr);
        logic [NREQ-1:0] g;
        g = '0;
        if (m_idx >= 0) g[m_idx] = 1'b1;
        return {terr, (m_idx >= 0), 2'(m_owner), g};
    endfunction

    task automatic model_reset();
        m_idx   = -1;
        m_owner = NREQ - 1;
        m_len   = 0;
        exp_q.delete();
        exp_q.push_back(model_pack(1'b0));
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
        bit terr;
        bit rls;
        int w;
        terr = 1'b0;
        if (m_idx >= 0) begin
            m_len++;
            rls = !r[m_idx] || l[m_idx];
            if (rls || (TO_EN && m_len >= TO_V)) begin
                terr  = !rls;
                m_idx = -1;
            end
        end else begin
            w = rr_pick(r, m_owner);
            if (w >= 0) begin
                m_idx   = w;
                m_owner = w;
                m_len   = 0;
            end
        end
        exp_q.push_back(model_pack(terr));
    endtask

    // scoreboard: compare DUT outputs with the oldest expected entry
    task automatic check_pop();
        logic [7:0] e;
        check("q_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e[3:0]));
            check("owner", 32'(owner), 32'(e[5:4]));
            check("busy", 32'(busy), 32'(e[6]));
            check("timeout_err", 32'(timeout_err), 32'(e[7]));
        end
    endtask

    // driver: called at a falling edge; drives, lets one rising edge pass,
    // then checks at the next falling edge
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        model_step(r, l);
        @(negedge clk);
        check_pop();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_pop();
    endtask

    logic [NREQ-1:0] t1_l   [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic [NREQ-1:0] t1_exp [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic [NREQ-1:0] t2_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] l;
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        @(negedge clk);
        apply_reset();
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_gnt", 32'(gnt), 32'd0);

        // single requester, last on its third grant cycle
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0001, t1_l[i]);
            check("t1_gnt", 32'(gnt), 32'(t1_exp[i]));
        end

        // all requesting, one-beat grants rotate 0,1,2,3,0
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(4'b1111, 4'b1111);
            check("t2_gnt", 32'(gnt), 32'(t2_exp[i]));
        end

        // owner 2 withdraws while 1 waits
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        cyc(4'b0100, 4'b0000);
        check("t3_gnt2", 32'(gnt), 32'b0100);
        cyc(4'b0110, 4'b0000);
        cyc(4'b0010, 4'b0000);
        check("t3_turn", 32'(gnt), 32'd0);
        check("t3_turn_owner", 32'(owner), 32'd2);
        cyc(4'b0010, 4'b0000);
        check("t3_gnt1", 32'(gnt), 32'b0010);
        check("t3_owner", 32'(owner), 32'd1);

`ifdef RISKY_BUS_ARB_TIMEOUT_EN
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0011, 4'b0000);
            check("to_hold", 32'(gnt), 32'b0001);
        end
        cyc(4'b0011, 4'b0000);
        check("to_turn", 32'(gnt), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        cyc(4'b0011, 4'b0000);
        check("to_next", 32'(gnt), 32'b0010);
        check("to_err_clr", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 3; i++) cyc(4'b0011, 4'b0000);
        cyc(4'b0011, 4'b0010);
        check("to_last_turn", 32'(gnt), 32'd0);
        check("to_last_err", 32'(timeout_err), 32'd0);
`endif

        // asynchronous reset in the middle of a grant
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        cyc(4'b0100, 4'b0000);
        check("ar_gnt", 32'(gnt), 32'b0100);
        #3;
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        model_reset();
        #1;
        check("ar_gnt0", 32'(gnt), 32'd0);
        check("ar_busy0", 32'(busy), 32'd0);
        check("ar_owner", 32'(owner), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        check_pop();
        cyc(4'b1111, 4'b0000);
        check("ar_first", 32'(gnt), 32'b0001);

        // randomized traffic with sticky requests
        r = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 9) < 3) r[b] = ~r[b];
            end
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cyc(r, l);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
